// File: rtl/instr_issue.sv
// Instruction fetch-and-issue unit: single-outstanding fetch port, small issue FIFO, redirect and halt.
// Define ISSUE_PREFETCH_EN for a 2-entry prefetch buffer; the default build uses a 1-entry buffer.
module instr_issue #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'b1111
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [3:0]         issue_opcode,
    output logic [PC_W-1:0]    issue_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

`ifdef ISSUE_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALT} state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    state_e                  state_q, state_d;
    logic [PC_W-1:0]         fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]         req_addr_q, req_addr_d;
    logic                    halted_q, halted_d;
    entry_t [DEPTH-1:0]      ent_q, ent_d;
    logic   [DEPTH-1:0]      vld_q, vld_d;

    logic slot_free, fire, halt_fire, push, flush, placed;

    // Entries stay packed from index 0, so the top valid bit alone means full.
    assign slot_free = ~vld_q[DEPTH-1];
    assign fire      = vld_q[0] & issue_ready & ~redirect_valid;
    assign halt_fire = fire & (ent_q[0].instr[INSTR_W-1 -: 4] == HALT_OP);
    assign flush     = redirect_valid | halt_fire;
    assign push      = (state_q == S_WAIT) & mem_rvalid & ~flush;

    // Held low during reset; a halting fire suppresses the request in its own cycle.
    assign mem_req  = reset_n & (state_q == S_IDLE) & ~halted_q & slot_free
                    & ~redirect_valid & ~halt_fire;
    assign mem_addr = fetch_pc_q;

    assign issue_valid  = vld_q[0];
    assign issue_instr  = ent_q[0].instr;
    assign issue_opcode = ent_q[0].instr[INSTR_W-1 -: 4];
    assign issue_pc     = ent_q[0].pc;
    assign halted       = halted_q;

    always_comb begin
        ent_d  = ent_q;
        vld_d  = vld_q;
        placed = 1'b0;
        if (flush) begin
            vld_d = '0;
        end else begin
            if (fire) begin
                for (int i = 0; i < DEPTH-1; i++) begin
                    ent_d[i] = ent_q[i+1];
                    vld_d[i] = vld_q[i+1];
                end
                vld_d[DEPTH-1] = 1'b0;
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!vld_d[i] && !placed) begin
                        ent_d[i].instr = mem_rdata;
                        ent_d[i].pc    = req_addr_q;
                        vld_d[i]       = 1'b1;
                        placed         = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        halted_d   = halted_q;

        if (mem_req) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            req_addr_d = fetch_pc_q;
        end
        if (halt_fire) halted_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (halt_fire)    state_d = S_HALT;
                else if (mem_req) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid)     state_d = halt_fire ? S_HALT : S_IDLE;
                else if (halt_fire) state_d = S_DROP;
            end
            S_DROP: begin
                if (mem_rvalid) state_d = halted_q ? S_HALT : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // A response landing in the redirect cycle retires the outstanding fetch, so no DROP.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            if ((state_q == S_WAIT || state_q == S_DROP) && !mem_rvalid) state_d = S_DROP;
            else                                                        state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            halted_q   <= 1'b0;
            ent_q      <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            halted_q   <= halted_d;
            ent_q      <= ent_d;
            vld_q      <= vld_d;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed table, corner sequences, randomized run vs queue model.
module tb_instr_issue;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef ISSUE_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk, reset_n;
    logic        mem_req, mem_rvalid, issue_valid, issue_ready, redirect_valid, halted;
    logic [15:0] mem_addr, mem_rdata, issue_instr, issue_pc, redirect_pc;
    logic [3:0]  issue_opcode;

    instr_issue #(.PC_W(16), .INSTR_W(16), .RESET_PC(RESET_PC), .HALT_OP(4'b1111)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_opcode(issue_opcode), .issue_pc(issue_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [15:0] instr; logic [15:0] pc; } ent_t;
    typedef struct { logic rdy; logic e_req; logic [15:0] e_addr; logic e_valid; logic [15:0] e_pc; } vec_t;

    // Reference model: queue of buffered words plus outstanding-fetch flags.
    ent_t        mq[$];
    bit          m_out, m_keep, m_halted;
    logic [15:0] m_fpc, m_raddr;

    // Memory responder
    bit          pend, stale_inj, rand_words, halt_en;
    logic [15:0] pend_addr, halt_addr;
    int          pend_cnt, lat_min, lat_max;

    logic        s_req, s_valid, s_halted;
    logic [15:0] s_addr, s_pc, s_instr;
    logic [3:0]  s_op;

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [15:0] w;
        if (halt_en && a == halt_addr) w = 16'hF000;
        else if (rand_words) begin
            w = {4'(a % 16'd15), a[11:0]};
            if (a % 16'd29 == 16'd28) w[15:12] = 4'hF;
        end else w = 16'h4000 | a;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_keep = 0; m_halted = 0; m_fpc = RESET_PC; m_raddr = '0;
    endtask

    // Called at posedge+1; drives one cycle, checks, advances the model, returns at next posedge+1.
    task automatic cycle(input logic rdv, input logic [15:0] rpc, input logic rdy);
        logic e_req, e_valid, fire, hfire;
        ent_t h, t;
        redirect_valid = rdv; redirect_pc = rpc; issue_ready = rdy;
        mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
        if (stale_inj) begin
            mem_rvalid = 1'b1; mem_rdata = 16'hDEAD; stale_inj = 0;
        end else if (pend) begin
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1; mem_rdata = word_of(pend_addr); pend = 0;
            end else pend_cnt--;
        end
        #1;
        e_valid = (mq.size() > 0);
        h.instr = '0; h.pc = '0;
        if (e_valid) h = mq[0];
        fire  = e_valid & rdy & ~rdv;
        hfire = fire && (h.instr[15:12] == 4'hF);
        e_req = !m_out && !m_halted && (mq.size() < DEPTH) && !rdv && !hfire;

        s_req = mem_req; s_addr = mem_addr; s_valid = issue_valid; s_pc = issue_pc;
        s_instr = issue_instr; s_op = issue_opcode; s_halted = halted;

        chk("mem_req", mem_req, e_req);
        if (e_req) chk("mem_addr", mem_addr, m_fpc);
        chk("issue_valid", issue_valid, e_valid);
        if (e_valid) begin
            chk("issue_pc", issue_pc, h.pc);
            chk("issue_instr", issue_instr, h.instr);
            chk("issue_opcode", issue_opcode, h.instr[15:12]);
        end
        chk("halted", halted, m_halted);

        if (mem_req) begin
            pend = 1; pend_addr = mem_addr;
            pend_cnt = $urandom_range(lat_max, lat_min) - 1;
        end

        if (rdv) begin
            mq.delete(); m_fpc = rpc; m_halted = 0;
            if (m_out && !mem_rvalid) m_keep = 0;
            else m_out = 0;
        end else begin
            if (fire) begin
                void'(mq.pop_front());
                if (hfire) begin mq.delete(); m_halted = 1; m_keep = 0; end
            end
            if (m_out && mem_rvalid) begin
                if (m_keep) begin t.instr = mem_rdata; t.pc = m_raddr; mq.push_back(t); end
                m_out = 0;
            end
            if (e_req) begin m_out = 1; m_keep = 1; m_raddr = m_fpc; m_fpc = m_fpc + 16'd1; end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input bit drop_pend);
        reset_n = 1'b0; redirect_valid = 0; redirect_pc = '0; issue_ready = 0; mem_rvalid = 0;
        model_reset();
        if (drop_pend) pend = 0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_issue_instr", issue_instr, 16'h0);
        chk("rst_issue_opcode", issue_opcode, 4'h0);
        chk("rst_issue_pc", issue_pc, 16'h0);
        chk("rst_halted", halted, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_until_req(input int maxc, input logic rdy, output bit found);
        found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            cycle(1'b0, 16'h0, rdy);
            found = s_req;
        end
    endtask

    task automatic run_until_valid(input int maxc, input logic rdy, output bit found);
        found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            cycle(1'b0, 16'h0, rdy);
            found = s_valid;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        bit   found;
        int   nreq;

`ifdef ISSUE_PREFETCH_EN
        tbl[0] = '{1, 1, 16'd0, 0, 16'd0};
        tbl[1] = '{1, 0, 16'd0, 0, 16'd0};
        tbl[2] = '{1, 1, 16'd1, 1, 16'd0};
        tbl[3] = '{1, 0, 16'd0, 0, 16'd0};
        tbl[4] = '{1, 1, 16'd2, 1, 16'd1};
        tbl[5] = '{1, 0, 16'd0, 0, 16'd0};
        tbl[6] = '{1, 1, 16'd3, 1, 16'd2};
        tbl[7] = '{1, 0, 16'd0, 0, 16'd0};
        tbl[8] = '{1, 1, 16'd4, 1, 16'd3};
`else
        tbl[0] = '{1, 1, 16'd0, 0, 16'd0};
        tbl[1] = '{1, 0, 16'd0, 0, 16'd0};
        tbl[2] = '{1, 0, 16'd0, 1, 16'd0};
        tbl[3] = '{1, 1, 16'd1, 0, 16'd0};
        tbl[4] = '{1, 0, 16'd0, 0, 16'd0};
        tbl[5] = '{1, 0, 16'd0, 1, 16'd1};
        tbl[6] = '{1, 1, 16'd2, 0, 16'd0};
        tbl[7] = '{1, 0, 16'd0, 0, 16'd0};
        tbl[8] = '{1, 0, 16'd0, 1, 16'd2};
`endif
        pend = 0; stale_inj = 0; rand_words = 0; halt_en = 0; halt_addr = '0;
        pend_addr = '0; pend_cnt = 0; lat_min = 1; lat_max = 1;
        reset_n = 1'b1; redirect_valid = 0; redirect_pc = '0; issue_ready = 0;
        mem_rvalid = 0; mem_rdata = '0;
        #2;
        do_reset(1);

        // Startup cadence with 1-cycle memory and decoder always ready
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 16'h0, tbl[i].rdy);
            chk("tbl_req", s_req, tbl[i].e_req);
            if (tbl[i].e_req) chk("tbl_addr", s_addr, tbl[i].e_addr);
            chk("tbl_valid", s_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk("tbl_pc", s_pc, tbl[i].e_pc);
                chk("tbl_opcode", s_op, 4'b0100);
            end
        end

        // Decoder stall: buffer fills, fetch stops, then drains in order
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 16'h0, 1'b0);
            if (i >= 6 && s_req) nreq++;
        end
        chk("stall_req_stops", nreq, 0);
        chk("stall_valid_held", s_valid, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 16'h0, 1'b1);

        // Redirect while a fetch is outstanding
        lat_min = 3; lat_max = 3;
        run_until_req(20, 1'b1, found);
        chk("redir_wait_found_req", found, 1'b1);
        cycle(1'b1, 16'h0080, 1'b1);
        run_until_req(20, 1'b1, found);
        chk("redir_wait_req", found, 1'b1);
        chk("redir_wait_addr", s_addr, 16'h0080);
        run_until_valid(20, 1'b1, found);
        chk("redir_wait_valid", found, 1'b1);
        chk("redir_wait_pc", s_pc, 16'h0080);

        // Redirect in the same cycle as a would-be issue transfer
        lat_min = 1; lat_max = 1;
        run_until_valid(20, 1'b0, found);
        chk("redir_fire_found", found, 1'b1);
        cycle(1'b1, 16'h0040, 1'b1);
        chk("redir_fire_head_seen", s_valid, 1'b1);
        cycle(1'b0, 16'h0, 1'b1);
        chk("redir_fire_empty", s_valid, 1'b0);
        run_until_valid(20, 1'b1, found);
        chk("redir_fire_valid", found, 1'b1);
        chk("redir_fire_pc", s_pc, 16'h0040);

        // Halt word at address 5, then restart via redirect
        halt_en = 1; halt_addr = 16'd5;
        cycle(1'b1, 16'd3, 1'b1);
        nreq = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1'b0, 16'h0, 1'b1);
            if (i >= 13 && s_req) nreq++;
        end
        chk("halt_flag", s_halted, 1'b1);
        chk("halt_no_req", nreq, 0);
        cycle(1'b1, 16'h0010, 1'b1);
        cycle(1'b0, 16'h0, 1'b1);
        chk("halt_cleared", s_halted, 1'b0);
        chk("halt_resume_req", s_req, 1'b1);
        chk("halt_resume_addr", s_addr, 16'h0010);
        halt_en = 0;

        // Reset during an outstanding fetch, late response afterwards
        lat_min = 6; lat_max = 6;
        run_until_req(20, 1'b1, found);
        cycle(1'b0, 16'h0, 1'b1);
        do_reset(1);
        lat_min = 1; lat_max = 1;
        stale_inj = 1;
        cycle(1'b0, 16'h0, 1'b1);
        chk("rst_first_req", s_req, 1'b1);
        chk("rst_first_addr", s_addr, RESET_PC);
        run_until_valid(20, 1'b1, found);
        chk("rst_first_valid", found, 1'b1);
        chk("rst_first_pc", s_pc, RESET_PC);
        chk("rst_first_instr", s_instr, 16'h4000);

        // Randomized traffic against the model
        rand_words = 1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2500; i++) begin
            logic        rdv;
            logic [15:0] rpc;
            rdv = ($urandom_range(99, 0) < 3);
            rpc = ($urandom_range(9, 0) == 0) ? 16'hFFFE : 16'($urandom_range(200, 0));
            cycle(rdv, rpc, ($urandom_range(99, 0) < 70));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
